// File: rtl/rotary_pkg.sv
// Shared quadrature constants and the Gray-code transition classifier
// used by the rotary encoder front end.
package rotary_pkg;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;

    typedef struct packed {
        logic valid;
        logic dir;
        logic illegal;
    } qdec_t;

    // CW walks 00->10->11->01->00; a jump across the cycle is illegal.
    function automatic qdec_t next_dir(input logic [1:0] prev, input logic [1:0] cur);
        qdec_t r;
        r = '0;
        case ({prev, cur})
            {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: begin
                r.valid = 1'b1;
                r.dir   = DIR_CW;
            end
            {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: begin
                r.valid = 1'b1;
                r.dir   = DIR_CCW;
            end
            {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: r.illegal = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Agreement filter: output follows din once FILT_LEN consecutive samples agree.
// Latency FILT_LEN edges from first sample; no backpressure, free-running.
module debounce_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [FILT_LEN-1:0] shReg;
    logic [FILT_LEN-1:0] shNext;

    assign shNext = {shReg[FILT_LEN-2:0], din};

    always_ff @(posedge clk) begin
        if (rst) begin
            shReg <= '0;
            dout  <= 1'b0;
        end else begin
            shReg <= shNext;
            if (&shNext) begin
                dout <= 1'b1;
            end else if (~|shNext) begin
                dout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rotary_decoder.sv
// Rotary encoder front end: debounce, Gray decode, position counter, press detect.
// Outputs registered one edge after the filtered levels; no backpressure, pulses are fire-and-forget.
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int FILT_LEN  = 4,
    parameter int CNT_W     = 8,
    parameter int WRAP      = 1,
    parameter int X4        = 0,
    parameter int CTR_CLEAR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rot_a,
    input  logic             rot_b,
    input  logic             rot_ctr,
    output logic             a_filt,
    output logic             b_filt,
    output logic             ctr_filt,
    output logic             step,
    output logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             press,
    output logic             err
);

    localparam logic [4:0] ARM_LEN = 5'(FILT_LEN + 1);
    localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [4:0]              armCnt;
    logic                    armed;
    logic [1:0]              prevAb;
    logic [1:0]              curAb;
    logic                    prevCtr;
    logic                    seqVld;
    logic                    seqDir;
    qdec_t                   qd;
    logic                    stepNxt;
    logic                    dirNxt;
    logic                    errNxt;
    logic                    pressNxt;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cntNxt;

    debounce_filter #(.FILT_LEN(FILT_LEN)) uFiltA (.clk(clk), .rst(rst), .din(rot_a),   .dout(a_filt));
    debounce_filter #(.FILT_LEN(FILT_LEN)) uFiltB (.clk(clk), .rst(rst), .din(rot_b),   .dout(b_filt));
    debounce_filter #(.FILT_LEN(FILT_LEN)) uFiltC (.clk(clk), .rst(rst), .din(rot_ctr), .dout(ctr_filt));

    assign armed = (armCnt == ARM_LEN);
    assign curAb = {a_filt, b_filt};
    assign qd    = next_dir(prevAb, curAb);
    assign count = cnt;

    // In detent mode a step needs the transition into 00 to continue the
    // direction of the one before it, so a mid-cycle reversal is ignored.
    always_comb begin
        stepNxt  = 1'b0;
        dirNxt   = dir;
        errNxt   = 1'b0;
        pressNxt = 1'b0;
        cntNxt   = cnt;
        if (armed) begin
            errNxt   = qd.illegal;
            pressNxt = ctr_filt & ~prevCtr;
            if (qd.valid && (X4 != 0 || (curAb == Q00 && seqVld && seqDir == qd.dir))) begin
                stepNxt = 1'b1;
                dirNxt  = qd.dir;
            end
        end
        if (stepNxt) begin
            if (dirNxt == DIR_CW) begin
                if (WRAP != 0 || cnt != CNT_MAX) cntNxt = cnt + CNT_W'(1);
            end else begin
                if (WRAP != 0 || cnt != CNT_MIN) cntNxt = cnt - CNT_W'(1);
            end
        end
        if (pressNxt && CTR_CLEAR != 0) cntNxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armCnt  <= '0;
            prevAb  <= Q00;
            prevCtr <= 1'b0;
            seqVld  <= 1'b0;
            seqDir  <= DIR_CCW;
            step    <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            prevAb  <= curAb;
            prevCtr <= ctr_filt;
            step    <= stepNxt;
            dir     <= dirNxt;
            err     <= errNxt;
            press   <= pressNxt;
            cnt     <= cntNxt;
            if (!armed) begin
                armCnt <= armCnt + 5'd1;
                seqVld <= 1'b0;
            end else if (qd.illegal) begin
                seqVld <= 1'b0;
            end else if (qd.valid) begin
                seqVld <= 1'b1;
                seqDir <= qd.dir;
            end
        end
    end

endmodule

// File: tb/tb_rotary_decoder.sv
// Four differently configured decoders share one randomised stimulus stream and
// are compared every cycle against a run-length / phase-arithmetic reference model.
module tb_rotary_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, rotA = 1'b0, rotB = 1'b0, rotCtr = 1'b0;
    logic aF [4], bF [4], cF [4], stp [4], dr [4], prs [4], er [4];
    logic [7:0] cnt0, cnt3;
    logic [3:0] cnt1, cnt2;

    int total = 0, bad = 0;

    // configuration per instance: FILT_LEN, CNT_W, WRAP, X4, CTR_CLEAR
    int cfgFl [4]   = '{4, 4, 4, 3};
    int cfgW [4]    = '{8, 4, 4, 8};
    int cfgWrap [4] = '{1, 1, 0, 0};
    int cfgX4 [4]   = '{0, 1, 1, 0};
    int cfgClr [4]  = '{0, 1, 0, 1};

    rotary_decoder #(.FILT_LEN(4), .CNT_W(8), .WRAP(1), .X4(0), .CTR_CLEAR(0)) u0 (
        .clk(clk), .rst(rst), .rot_a(rotA), .rot_b(rotB), .rot_ctr(rotCtr),
        .a_filt(aF[0]), .b_filt(bF[0]), .ctr_filt(cF[0]), .step(stp[0]), .dir(dr[0]),
        .count(cnt0), .press(prs[0]), .err(er[0]));
    rotary_decoder #(.FILT_LEN(4), .CNT_W(4), .WRAP(1), .X4(1), .CTR_CLEAR(1)) u1 (
        .clk(clk), .rst(rst), .rot_a(rotA), .rot_b(rotB), .rot_ctr(rotCtr),
        .a_filt(aF[1]), .b_filt(bF[1]), .ctr_filt(cF[1]), .step(stp[1]), .dir(dr[1]),
        .count(cnt1), .press(prs[1]), .err(er[1]));
    rotary_decoder #(.FILT_LEN(4), .CNT_W(4), .WRAP(0), .X4(1), .CTR_CLEAR(0)) u2 (
        .clk(clk), .rst(rst), .rot_a(rotA), .rot_b(rotB), .rot_ctr(rotCtr),
        .a_filt(aF[2]), .b_filt(bF[2]), .ctr_filt(cF[2]), .step(stp[2]), .dir(dr[2]),
        .count(cnt2), .press(prs[2]), .err(er[2]));
    rotary_decoder #(.FILT_LEN(3), .CNT_W(8), .WRAP(0), .X4(0), .CTR_CLEAR(1)) u3 (
        .clk(clk), .rst(rst), .rot_a(rotA), .rot_b(rotB), .rot_ctr(rotCtr),
        .a_filt(aF[3]), .b_filt(bF[3]), .ctr_filt(cF[3]), .step(stp[3]), .dir(dr[3]),
        .count(cnt3), .press(prs[3]), .err(er[3]));

    // reference model state
    int mRun [4][3];
    int mLast [4][3];
    int mFilt [4][3];
    int mArm [4], mPrevAb [4], mPrevCtr [4], mCount [4], mLastDir [4];
    int mDir [4], mStep [4], mPress [4], mErr [4];

    task automatic checkVal(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // position of an A/B level pair along the CW Gray cycle 00,10,11,01
    function automatic int gpos(input int ab);
        case (ab)
            0: return 0;
            2: return 1;
            3: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic modelEdge(input int i, input int r, input int raw0, input int raw1, input int raw2);
        int raw [3];
        int fl, cur, d, td, lo, hi;
        raw[0] = raw0; raw[1] = raw1; raw[2] = raw2;
        fl = cfgFl[i];
        if (r != 0) begin
            for (int k = 0; k < 3; k++) begin
                mRun[i][k] = fl; mLast[i][k] = 0; mFilt[i][k] = 0;
            end
            mArm[i] = 0; mPrevAb[i] = 0; mPrevCtr[i] = 0; mCount[i] = 0; mLastDir[i] = 0;
            mDir[i] = 0; mStep[i] = 0; mPress[i] = 0; mErr[i] = 0;
            return;
        end
        lo = -(1 << (cfgW[i] - 1));
        hi = (1 << (cfgW[i] - 1)) - 1;
        cur = mFilt[i][0] * 2 + mFilt[i][1];
        mStep[i] = 0; mErr[i] = 0; mPress[i] = 0;
        if (mArm[i] < fl + 1) begin
            mArm[i]++;
            mLastDir[i] = 0;
        end else begin
            d = (gpos(cur) - gpos(mPrevAb[i]) + 4) % 4;
            if (d == 2) begin
                mErr[i] = 1;
                mLastDir[i] = 0;
            end else if (d != 0) begin
                td = (d == 1) ? 1 : -1;
                if (cfgX4[i] != 0 || (cur == 0 && mLastDir[i] == td)) begin
                    mStep[i] = 1;
                    mDir[i] = (td == 1) ? 1 : 0;
                    mCount[i] += td;
                    if (mCount[i] > hi) mCount[i] = (cfgWrap[i] != 0) ? lo : hi;
                    if (mCount[i] < lo) mCount[i] = (cfgWrap[i] != 0) ? hi : lo;
                end
                mLastDir[i] = td;
            end
            mPress[i] = (mFilt[i][2] == 1 && mPrevCtr[i] == 0) ? 1 : 0;
            if (mPress[i] != 0 && cfgClr[i] != 0) mCount[i] = 0;
        end
        mPrevAb[i] = cur;
        mPrevCtr[i] = mFilt[i][2];
        for (int k = 0; k < 3; k++) begin
            if (raw[k] == mLast[i][k]) begin
                if (mRun[i][k] < 1000) mRun[i][k]++;
            end else begin
                mRun[i][k] = 1;
            end
            mLast[i][k] = raw[k];
            if (mRun[i][k] >= fl) mFilt[i][k] = raw[k];
        end
    endtask

    function automatic int obsCount(input int i);
        case (i)
            0: return int'($signed(cnt0));
            1: return int'($signed(cnt1));
            2: return int'($signed(cnt2));
            default: return int'($signed(cnt3));
        endcase
    endfunction

    task automatic tick(input int r, input int a, input int b, input int c);
        @(negedge clk);
        rst = 1'(r); rotA = 1'(a); rotB = 1'(b); rotCtr = 1'(c);
        @(posedge clk);
        for (int i = 0; i < 4; i++) modelEdge(i, r, a, b, c);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("u%0d.a_filt", i), int'(aF[i]), mFilt[i][0]);
            checkVal($sformatf("u%0d.b_filt", i), int'(bF[i]), mFilt[i][1]);
            checkVal($sformatf("u%0d.ctr_filt", i), int'(cF[i]), mFilt[i][2]);
            checkVal($sformatf("u%0d.step", i), int'(stp[i]), mStep[i]);
            checkVal($sformatf("u%0d.dir", i), int'(dr[i]), mDir[i]);
            checkVal($sformatf("u%0d.press", i), int'(prs[i]), mPress[i]);
            checkVal($sformatf("u%0d.err", i), int'(er[i]), mErr[i]);
            checkVal($sformatf("u%0d.count", i), obsCount(i), mCount[i]);
        end
    endtask

    // encoder phase 0..3 along the CW cycle and current push level
    int pos = 0;
    int ctr = 0;

    function automatic int abOf(input int p);
        case (p & 3)
            0: return 0;
            1: return 2;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) tick(0, abOf(pos) >> 1, abOf(pos) & 1, ctr);
    endtask

    task automatic walk(input int d, input int n, input int len);
        for (int k = 0; k < n; k++) begin
            pos = (pos + d + 4) & 3;
            hold(len);
        end
    endtask

    task automatic glitchA(input int len);
        for (int k = 0; k < len; k++) tick(0, ((abOf(pos) >> 1) ^ 1), abOf(pos) & 1, ctr);
        hold(10);
    endtask

    initial begin
        // reset with every raw input high, then hold high through arming
        for (int k = 0; k < 3; k++) tick(1, 1, 1, 1);
        for (int k = 0; k < 10; k++) tick(0, 1, 1, 1);
        pos = 2; ctr = 1;
        hold(2);
        ctr = 0;
        walk(1, 2, 10);               // 11 -> 01 -> 00
        walk(1, 4, 10);               // one CW detent
        walk(-1, 4, 10);              // one CCW detent
        glitchA(3);
        walk(1, 2, 10);               // reversal mid-detent
        walk(-1, 2, 10);
        walk(1, 48, 6);               // twelve CW detents: wrap / saturate
        walk(-1, 40, 6);
        pos = (pos + 2) & 3;          // both lines toggle together
        hold(10);
        walk(1, 4, 10);
        // press arriving on the same edge as the final CW transition
        walk(1, 3, 10);
        pos = 0; ctr = 1;
        hold(10);
        ctr = 0;
        hold(10);
        walk(1, 2, 8);                // reset in the middle of a detent
        tick(1, abOf(pos) >> 1, abOf(pos) & 1, ctr);
        hold(12);
        walk(1, 4, 8);

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: walk(1, 1, $urandom_range(1, 12));
                3, 4, 5: walk(-1, 1, $urandom_range(1, 12));
                6: begin
                    pos = (pos + 2) & 3;
                    hold($urandom_range(3, 10));
                end
                7: begin
                    ctr ^= 1;
                    hold($urandom_range(1, 10));
                end
                8: glitchA($urandom_range(1, 5));
                default: begin
                    if ($urandom_range(0, 4) == 0) tick(1, abOf(pos) >> 1, abOf(pos) & 1, ctr);
                    hold($urandom_range(1, 6));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotary_decoder.md
# rotary_decoder

Parametrised quadrature rotary-encoder front end for the Spartan-3E board peripherals. It debounces the raw A, B and centre-push inputs with a configurable-length agreement filter, then decodes the filtered A/B pair with a Gray-code state machine into single-cycle step pulses with direction. Steps drive a signed position counter with a selectable wrap or saturate mode. It sits between the board pins (already 2-FF synchronised upstream) and user logic such as menu or LED controllers.

## Interface
- FILT_LEN, 4: filter depth; a level is accepted only after FILT_LEN consecutive equal samples; legal range 2..16.
- CNT_W, 8: position counter width, two's complement; legal range 2..32.
- WRAP, 1: 1 = counter wraps modulo 2^CNT_W; 0 = counter saturates.
- X4, 0: 1 = one step per valid Gray transition; 0 = one step per full detent cycle.
- CTR_CLEAR, 0: 1 = a debounced press zeroes the counter.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rot_a  in  1  raw encoder A.
- rot_b  in  1  raw encoder B.
- rot_ctr  in  1  raw centre push, high = pressed.
- a_filt, b_filt, ctr_filt  out  1 each  debounced levels, same polarity as the inputs.
- step  out  1  one-cycle pulse per decoded step.
- dir  out  1  direction of the latest step; 1 = CW; held between steps.
- count  out  CNT_W  signed position.
- press  out  1  one-cycle pulse on the debounced rising edge of rot_ctr.
- err  out  1  one-cycle pulse on an illegal A/B transition.

## Operation
- **Filter, per input:** a FILT_LEN-bit shift register takes the raw input at each edge.
  - Filtered level goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds.
  - The decision uses the shift value after this edge's shift.
- **Arming:** after reset, a counter runs for FILT_LEN+1 cycles. During that time the decoder is disarmed: no step or err, and prev_ab tracks {a_filt,b_filt}. Decoding starts on the following cycle.
- **Quadrature decode:** state {a_filt,b_filt} is compared with registered prev_ab each cycle.
  - CW sequence: 00→10→11→01→00. CCW sequence: 00→01→11→10→00.
  - Both bits changing in one cycle: err=1, no step, prev_ab updated.
  - X4=1: every valid transition gives step=1 with dir set to the sequence direction.
  - X4=0: only 01→00 (CW) or 10→00 (CCW) gives a step. Reversal mid-cycle gives no step.
- **Counter:** on step, count ±1.
  - WRAP=1: max+1 → min and min−1 → max.
  - WRAP=0: count holds at 2^(CNT_W−1)−1 or −2^(CNT_W−1); step still pulses.
- **Press:** press=1 when ctr_filt goes 0→1. Release produces no pulse.
  - With CTR_CLEAR=1, press sets count to 0. If a step occurs in the same cycle, the clear wins.
- **Reset values:** all shift registers 0; a_filt, b_filt, ctr_filt 0; prev_ab 00; count 0; dir 0; step, press, err 0; arming counter 0.
- Reset asserted mid-operation returns everything to reset values on the next edge and restarts arming.

## Timing
- Raw input change, held stable, is first sampled at edge 1. The filtered output changes at edge FILT_LEN.
- step, dir, count, press and err update at edge FILT_LEN+1, all registered.
- Bounce shorter than FILT_LEN cycles never reaches the filtered outputs.
- Steps can occur at most once per FILT_LEN cycles per input; no back-pressure, no handshake.
- count is valid every cycle; consumers sample it on step.

## Structure
- Package rotary_pkg:
  - DIR_CW=1'b1, DIR_CCW=1'b0.
  - 2-bit quadrature state constants Q00, Q01, Q10, Q11.
  - function next_dir(prev, cur) returning valid/dir/illegal.
- Sub-module debounce_filter (parameter FILT_LEN; ports clk, rst, din, dout), instantiated three times.
- Top holds the arming counter, decode logic, counter and edge detect.

## Test plan
- Reset with all inputs high, FILT_LEN=4: outputs 0 through reset; a_filt/b_filt/ctr_filt=1 at edge 4; no err or step during arming; press is not generated.
- X4=0, one CW detent (A/B 00→10→11→01→00, each held 10 cycles): exactly one step with dir=1, count 0→1. CCW detent: count 1→0, dir=0.
- X4=1, one CW detent: four steps, count=4. Glitch on A of 3 cycles with FILT_LEN=4: no change on a_filt.
- CNT_W=4: WRAP=1 at count=7 plus one CW step → −8. WRAP=0 at count=7 plus CW step → count stays 7, step=1.
- A and B toggled on the same cycle (00→11): err one cycle, no step, count unchanged; decoding resumes normally on the next valid transition.
- CTR_CLEAR=1, count=5, press coincident with a CW step → count=0, press=1, step=1; rst asserted mid-detent → all outputs 0 on the next edge.
